// File: rtl/elevator_pkg.sv
// Shared types and request-map helpers for the elevator car controller.
package elevator_pkg;

  // Upper bound on floors the helpers can scan; request maps are zero-extended to this width.
  localparam int unsigned MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen
  } state_t;

  typedef enum logic {
    DirUp,
    DirDown
  } dir_t;

  // Any request strictly above floor flr.
  function automatic logic req_above(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned flr);
    logic [MAX_FLOORS-1:0] upto;
    upto = (MAX_FLOORS'(2) << flr) - MAX_FLOORS'(1);
    return |(pend & ~upto);
  endfunction

  // Any request strictly below floor flr.
  function automatic logic req_below(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned flr);
    logic [MAX_FLOORS-1:0] under;
    under = (MAX_FLOORS'(1) << flr) - MAX_FLOORS'(1);
    return |(pend & under);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter with load/enable and a zero flag; used for travel and door timing.
module elevator_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: latches floor requests, steps the car and opens the door at served floors.
// Optional ELEV_EMERGENCY_STOP_EN adds an emergency input that freezes the car and its timers.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned FLOOR_W       = 2,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
`ifdef ELEV_EMERGENCY_STOP_EN
  input  logic                  emergency,
`endif
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  logic                  freeze;
  logic                  trv_load, trv_en, trv_zero;
  logic                  door_load, door_en, door_zero;
  logic [NUM_FLOORS-1:0] cur_mask, next_mask, set_mask, clr_mask;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  up_leg, here_pend, next_pend, above, below, ahead_next;
  logic                  req_in_range, req_here;

`ifdef ELEV_EMERGENCY_STOP_EN
  assign freeze = emergency;
`else
  assign freeze = 1'b0;
`endif

  assign up_leg     = (state_q == StMoveUp);
  // Saturate at the end floors so the car can never wrap around.
  assign next_floor = up_leg ? ((floor_q != TOP_FLOOR) ? floor_q + FLOOR_W'(1) : floor_q)
                             : ((floor_q != '0)        ? floor_q - FLOOR_W'(1) : floor_q);

  assign cur_mask   = NUM_FLOORS'(1) << floor_q;
  assign next_mask  = NUM_FLOORS'(1) << next_floor;
  assign here_pend  = |(pending_q & cur_mask);
  assign next_pend  = |(pending_q & next_mask);
  assign above      = req_above(MAX_FLOORS'(pending_q), 32'(floor_q));
  assign below      = req_below(MAX_FLOORS'(pending_q), 32'(floor_q));
  assign ahead_next = up_leg ? req_above(MAX_FLOORS'(pending_q), 32'(next_floor))
                             : req_below(MAX_FLOORS'(pending_q), 32'(next_floor));

  assign req_in_range = req_valid && (32'(req_floor) < NUM_FLOORS);
  // A request for the floor whose door is open holds the door instead of queueing.
  assign req_here     = req_in_range && (state_q == StDoorOpen) && (req_floor == floor_q);
  assign set_mask     = (req_in_range && !req_here) ? (NUM_FLOORS'(1) << req_floor) : '0;

  // Next-state logic; clear beats set so a request arriving as its floor is served is consumed.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    clr_mask  = '0;
    trv_load  = 1'b0;
    trv_en    = 1'b0;
    door_load = 1'b0;
    door_en   = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        StIdle: begin
          if (here_pend) begin
            state_d   = StDoorOpen;
            clr_mask  = cur_mask;
            door_load = 1'b1;
          end else if ((dir_q == DirUp) && above) begin
            state_d  = StMoveUp;
            trv_load = 1'b1;
          end else if ((dir_q == DirDown) && below) begin
            state_d  = StMoveDown;
            trv_load = 1'b1;
          end else if (above) begin
            state_d  = StMoveUp;
            dir_d    = DirUp;
            trv_load = 1'b1;
          end else if (below) begin
            state_d  = StMoveDown;
            dir_d    = DirDown;
            trv_load = 1'b1;
          end
        end
        StMoveUp, StMoveDown: begin
          if (trv_zero) begin
            floor_d = next_floor;
            if (next_pend) begin
              state_d   = StDoorOpen;
              clr_mask  = next_mask;
              door_load = 1'b1;
            end else if (ahead_next) begin
              trv_load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            trv_en = 1'b1;
          end
        end
        StDoorOpen: begin
          if (req_here) begin
            door_load = 1'b1;
          end else if (door_zero) begin
            state_d = StIdle;
          end else begin
            door_en = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      dir_q     <= DirUp;
      floor_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    current_floor = floor_q;
    moving_up     = (state_q == StMoveUp) && !freeze;
    moving_down   = (state_q == StMoveDown) && !freeze;
    door_open     = (state_q == StDoorOpen);
    pending       = pending_q;
    busy          = (state_q != StIdle) || (pending_q != '0);
  end

  elevator_timer #(
    .WIDTH(CNT_W)
  ) u_travel_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (trv_load),
    .load_value(TRAVEL_LOAD),
    .enable    (trv_en),
    .zero      (trv_zero)
  );

  elevator_timer #(
    .WIDTH(CNT_W)
  ) u_door_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (door_load),
    .load_value(DOOR_LOAD),
    .enable    (door_en),
    .zero      (door_zero)
  );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed scoreboard bench for elevator_scheduler (4-floor car plus a 3-floor car).
module tb_elevator_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_floor = '0;
  logic       r3_valid = 1'b0;
  logic [1:0] r3_floor = '0;
`ifdef ELEV_EMERGENCY_STOP_EN
  logic       emergency = 1'b0;
`endif

  logic [1:0] cur4, cur3;
  logic       up4, dn4, door4, busy4, up3, dn3, door3, busy3;
  logic [3:0] pend4;
  logic [2:0] pend3;

  always #5 clock = ~clock;

  elevator_scheduler #(
    .NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(8), .DOOR_CYCLES(6)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
`ifdef ELEV_EMERGENCY_STOP_EN
    .emergency    (emergency),
`endif
    .current_floor(cur4),
    .moving_up    (up4),
    .moving_down  (dn4),
    .door_open    (door4),
    .pending      (pend4),
    .busy         (busy4)
  );

  elevator_scheduler #(
    .NUM_FLOORS(3), .FLOOR_W(2), .TRAVEL_CYCLES(8), .DOOR_CYCLES(6)
  ) u_dut3 (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (r3_valid),
    .req_floor    (r3_floor),
`ifdef ELEV_EMERGENCY_STOP_EN
    .emergency    (1'b0),
`endif
    .current_floor(cur3),
    .moving_up    (up3),
    .moving_down  (dn3),
    .door_open    (door3),
    .pending      (pend3),
    .busy         (busy3)
  );

  typedef struct {
    int         due;
    string      tag;
    bit         sel;
    logic [9:0] exp;
  } sb_t;

  sb_t        sb[$];
  sb_t        ent;
  logic [9:0] obs;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         base;

  always @(posedge clock) cyc <= cyc + 1;

  // Observed vector: {floor, up, down, door, pending[3:0], busy}.
  always @(posedge clock) begin
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      obs = ent.sel ? {cur3, up3, dn3, door3, 1'b0, pend3, busy3}
                    : {cur4, up4, dn4, door4, pend4, busy4};
      checks++;
      assert (obs === ent.exp && ent.due == cyc) else begin
        failures++;
        $error("FAIL %s cycle=%0d due=%0d observed=%b expected=%b",
               ent.tag, cyc, ent.due, obs, ent.exp);
      end
    end
  end

  function automatic void exp_at(input int due, input string tag, input bit sel,
                                 input logic [1:0] fl, input logic up, input logic dn,
                                 input logic door, input logic [3:0] pend, input logic bsy);
    sb_t e;
    int  idx;
    e.due = due;
    e.tag = tag;
    e.sel = sel;
    e.exp = {fl, up, dn, door, pend, bsy};
    idx = 0;
    while (idx < sb.size() && sb[idx].due <= due) idx++;
    sb.insert(idx, e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic req(input logic [1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic req3(input logic [1:0] f);
    r3_valid = 1'b1;
    r3_floor = f;
    step(1);
    r3_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    reset = 1'b0;
    base = cyc;
    exp_at(base + 1, "reset", 0, 2'd0, 0, 0, 0, 4'b0000, 0);
    exp_at(base + 1, "reset3", 1, 2'd0, 0, 0, 0, 4'b0000, 0);
    step_to(base + 2);

    // Request at the current floor, then hold the door with a repeat request.
    base = cyc;
    exp_at(base + 1,  "t1_pend",     0, 2'd0, 0, 0, 0, 4'b0001, 1);
    exp_at(base + 2,  "t1_door",     0, 2'd0, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 5,  "t1_hold",     0, 2'd0, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 10, "t1_door_end", 0, 2'd0, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 11, "t1_close",    0, 2'd0, 0, 0, 0, 4'b0000, 0);
    req(2'd0);
    step_to(base + 4);
    req(2'd0);
    step_to(base + 12);

    // Out-of-range request on the 3-floor car is dropped; a valid one is taken.
    base = cyc;
    exp_at(base + 1, "t5_oor_pend", 1, 2'd0, 0, 0, 0, 4'b0000, 0);
    exp_at(base + 2, "t5_oor_busy", 1, 2'd0, 0, 0, 0, 4'b0000, 0);
    exp_at(base + 4, "t5_req2",     1, 2'd0, 0, 0, 0, 4'b0100, 1);
    exp_at(base + 5, "t5_move",     1, 2'd0, 1, 0, 0, 4'b0100, 1);
    req3(2'd3);
    step_to(base + 3);
    req3(2'd2);
    step_to(base + 6);

    // Travel 0 -> 3, one floor per 8 cycles.
    base = cyc;
    exp_at(base + 1,  "t2_pend",  0, 2'd0, 0, 0, 0, 4'b1000, 1);
    exp_at(base + 2,  "t2_start", 0, 2'd0, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 9,  "t2_f0",    0, 2'd0, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 10, "t2_f1",    0, 2'd1, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 18, "t2_f2",    0, 2'd2, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 25, "t2_f2end", 0, 2'd2, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 26, "t2_door",  0, 2'd3, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 31, "t2_door5", 0, 2'd3, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 32, "t2_idle",  0, 2'd3, 0, 0, 0, 4'b0000, 0);
    req(2'd3);
    step_to(base + 33);

    // Reverse from the top, then reset mid-move.
    base = cyc;
    exp_at(base + 1,  "rs_pend",  0, 2'd3, 0, 0, 0, 4'b0001, 1);
    exp_at(base + 2,  "rs_down",  0, 2'd3, 0, 1, 0, 4'b0001, 1);
    exp_at(base + 10, "rs_f2",    0, 2'd2, 0, 1, 0, 4'b0001, 1);
    exp_at(base + 13, "rs_reset", 0, 2'd0, 0, 0, 0, 4'b0000, 0);
    req(2'd0);
    step_to(base + 12);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step_to(base + 14);

    // Intermediate stop picked up on the way.
    base = cyc;
    exp_at(base + 4,  "t3_both",   0, 2'd0, 1, 0, 0, 4'b1010, 1);
    exp_at(base + 9,  "t3_f0",     0, 2'd0, 1, 0, 0, 4'b1010, 1);
    exp_at(base + 10, "t3_stop1",  0, 2'd1, 0, 0, 1, 4'b1000, 1);
    exp_at(base + 15, "t3_door5",  0, 2'd1, 0, 0, 1, 4'b1000, 1);
    exp_at(base + 16, "t3_idle",   0, 2'd1, 0, 0, 0, 4'b1000, 1);
    exp_at(base + 17, "t3_resume", 0, 2'd1, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 25, "t3_f2",     0, 2'd2, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 33, "t3_stop3",  0, 2'd3, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 39, "t3_done",   0, 2'd3, 0, 0, 0, 4'b0000, 0);
    req(2'd3);
    step_to(base + 3);
    req(2'd1);
    step_to(base + 40);

    // SCAN: finish the upward leg before reversing to a request behind.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    base = cyc;
    exp_at(base + 18, "t4_f2",     0, 2'd2, 1, 0, 0, 4'b1000, 1);
    exp_at(base + 20, "t4_req0",   0, 2'd2, 1, 0, 0, 4'b1001, 1);
    exp_at(base + 26, "t4_serve3", 0, 2'd3, 0, 0, 1, 4'b0001, 1);
    exp_at(base + 32, "t4_idle3",  0, 2'd3, 0, 0, 0, 4'b0001, 1);
    exp_at(base + 33, "t4_rev",    0, 2'd3, 0, 1, 0, 4'b0001, 1);
    exp_at(base + 41, "t4_f2",     0, 2'd2, 0, 1, 0, 4'b0001, 1);
    exp_at(base + 49, "t4_f1",     0, 2'd1, 0, 1, 0, 4'b0001, 1);
    exp_at(base + 57, "t4_serve0", 0, 2'd0, 0, 0, 1, 4'b0000, 1);
    exp_at(base + 63, "t4_done",   0, 2'd0, 0, 0, 0, 4'b0000, 0);
    req(2'd3);
    step_to(base + 19);
    req(2'd0);
    step_to(base + 64);

`ifdef ELEV_EMERGENCY_STOP_EN
    // Emergency stop for 5 cycles mid-travel delays arrival by 5 cycles.
    base = cyc;
    exp_at(base + 2,  "em_start",   0, 2'd0, 1, 0, 0, 4'b0100, 1);
    exp_at(base + 4,  "em_stop",    0, 2'd0, 0, 0, 0, 4'b0100, 1);
    exp_at(base + 6,  "em_latch",   0, 2'd0, 0, 0, 0, 4'b1100, 1);
    exp_at(base + 8,  "em_hold",    0, 2'd0, 0, 0, 0, 4'b1100, 1);
    exp_at(base + 9,  "em_release", 0, 2'd0, 1, 0, 0, 4'b1100, 1);
    exp_at(base + 14, "em_late",    0, 2'd0, 1, 0, 0, 4'b1100, 1);
    exp_at(base + 15, "em_f1",      0, 2'd1, 1, 0, 0, 4'b1100, 1);
    exp_at(base + 23, "em_door2",   0, 2'd2, 0, 0, 1, 4'b1000, 1);
    req(2'd2);
    step_to(base + 4);
    emergency = 1'b1;
    step(1);
    req(2'd3);
    step_to(base + 9);
    emergency = 1'b0;
    step_to(base + 24);
`endif

    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d expected=0 entries left", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
